// File: rtl/intc_pkg.sv
// intc_pkg: register offsets, FSM state encoding and hold-off counter width
// shared by the intc interrupt controller files.
package intc_pkg;

  localparam logic [1:0] REG_IE      = 2'd0;
  localparam logic [1:0] REG_IP      = 2'd1;
  localparam logic [1:0] REG_IMODE   = 2'd2;
  localparam logic [1:0] REG_HOLDOFF = 2'd3;

  localparam int CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ASSERT = 2'd1,
    HOLD   = 2'd2
  } state_e;

endpackage

// File: rtl/intc_sync.sv
// intc_sync: brings one asynchronous interrupt source into the clk domain
// through two flops and keeps a third flop of history for rising-edge detect.
module intc_sync
  import intc_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic level,
  output logic rise
);

  logic meta_q, meta_d;
  logic sync_q, sync_d;
  logic prev_q, prev_d;

  // Shift chain: raw input -> metastability flop -> synchronized -> history.
  always_comb begin
    meta_d = d;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  // Chain flops, cleared asynchronously.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign level = sync_q;
  assign rise  = sync_q & ~prev_q;

endmodule

// File: rtl/intc.sv
// intc: merges NUM_IRQS sources into one registered interrupt line with
// IE/IP/IMODE CSRs; the HOLDOFF register and HOLD state exist only when
// INTC_HOLDOFF_EN is defined.
module intc
  import intc_pkg::*;
#(
  parameter logic [4:0] BASE_ADDR = 5'h1c,
  parameter int         NUM_IRQS  = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [4:0]          csr_a,
  input  logic [7:0]          csr_di,
  input  logic                csr_we,
  output logic [7:0]          csr_do,
  input  logic                tick,
  input  logic [NUM_IRQS-1:0] irq_in,
  output logic                irq_out
);

  localparam logic [NUM_IRQS-1:0] ZERO_V = {NUM_IRQS{1'b0}};

  logic [NUM_IRQS-1:0] level_s, rise_s;

  for (genvar i = 0; i < NUM_IRQS; i++) begin : g_sync
    intc_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (irq_in[i]),
      .level (level_s[i]),
      .rise  (rise_s[i])
    );
  end

  logic [4:0]          off_s;
  logic                hit_s;
  logic [1:0]          reg_s;
  logic [NUM_IRQS-1:0] wdata_s;

  assign off_s   = csr_a - BASE_ADDR;
  assign hit_s   = (csr_a >= BASE_ADDR) && (off_s < 5'd4);
  assign reg_s   = off_s[1:0];
  assign wdata_s = csr_di[NUM_IRQS-1:0];

  logic [NUM_IRQS-1:0] ie_q, ie_d;
  logic [NUM_IRQS-1:0] ip_q, ip_d;
  logic [NUM_IRQS-1:0] imode_q, imode_d;
  logic [NUM_IRQS-1:0] w1c_s, set_s;
  logic                active_s;

  // CSR write decode and pending update; a new set wins over a W1C clear.
  always_comb begin
    ie_d    = ie_q;
    imode_d = imode_q;
    w1c_s   = ZERO_V;
    if (csr_we && hit_s) begin
      case (reg_s)
        REG_IE:    ie_d    = wdata_s;
        REG_IP:    w1c_s   = wdata_s;
        REG_IMODE: imode_d = wdata_s;
        default:   w1c_s   = ZERO_V;
      endcase
    end else begin
      w1c_s = ZERO_V;
    end
    set_s = (imode_q & rise_s) | (~imode_q & level_s);
    ip_d  = (ip_q & ~w1c_s) | set_s;
  end

  // Mask, pending and mode registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ie_q    <= ZERO_V;
      ip_q    <= ZERO_V;
      imode_q <= ZERO_V;
    end else begin
      ie_q    <= ie_d;
      ip_q    <= ip_d;
      imode_q <= imode_d;
    end
  end

  assign active_s = |(ip_q & ie_q);

`ifdef INTC_HOLDOFF_EN
  logic [CNT_W-1:0] holdoff_q, holdoff_d;
  logic [CNT_W-1:0] cnt_q;

  // Hold-off length register.
  always_comb begin
    if (csr_we && hit_s && (reg_s == REG_HOLDOFF)) begin
      holdoff_d = csr_di;
    end else begin
      holdoff_d = holdoff_q;
    end
  end

  // Hold-off length storage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      holdoff_q <= 8'd0;
    end else begin
      holdoff_q <= holdoff_d;
    end
  end
`else
  logic unused_s;
  assign unused_s = tick;
`endif

  state_e state_q;
  logic   irq_q;

  // Output FSM; HOLD counts tick pulses and only reloads cnt on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      irq_q   <= 1'b0;
`ifdef INTC_HOLDOFF_EN
      cnt_q   <= 8'd0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (active_s) begin
            state_q <= ASSERT;
            irq_q   <= 1'b1;
          end
        end
        ASSERT: begin
          if (!active_s) begin
            irq_q <= 1'b0;
`ifdef INTC_HOLDOFF_EN
            if (holdoff_q != 8'd0) begin
              state_q <= HOLD;
              cnt_q   <= holdoff_q;
            end else begin
              state_q <= IDLE;
            end
`else
            state_q <= IDLE;
`endif
          end
        end
`ifdef INTC_HOLDOFF_EN
        HOLD: begin
          irq_q <= 1'b0;
          if (tick) begin
            if (cnt_q == 8'd1) begin
              state_q <= IDLE;
            end else begin
              cnt_q <= cnt_q - 8'd1;
            end
          end
        end
`endif
        default: begin
          state_q <= IDLE;
          irq_q   <= 1'b0;
        end
      endcase
    end
  end

  assign irq_out = irq_q;

  logic [7:0] rdata_s;

  // Combinational read mux; zero when the address is outside this block.
  always_comb begin
    rdata_s = 8'h00;
    if (hit_s) begin
      case (reg_s)
        REG_IE:    rdata_s[NUM_IRQS-1:0] = ie_q;
        REG_IP:    rdata_s[NUM_IRQS-1:0] = ip_q;
        REG_IMODE: rdata_s[NUM_IRQS-1:0] = imode_q;
`ifdef INTC_HOLDOFF_EN
        REG_HOLDOFF: rdata_s = holdoff_q;
`endif
        default:   rdata_s = 8'h00;
      endcase
    end else begin
      rdata_s = 8'h00;
    end
  end

  assign csr_do = rdata_s;

endmodule
